lfm_sweep_ctrl: RTL and testbench

//  Upstream sequencer for the DDS LFM chirp core: produces the per-sample frequency tuning word (FTW)

---
 rtl/lfm_sweep_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lfm_sweep_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfm_sweep_ctrl.sv
// lfm_sweep_ctrl -- LFM chirp sequencer in front of the DDS phase accumulator.
//
// Generates the per-sample frequency tuning word ramp for each sweep. It also
// inserts optional idle gaps between sweeps and counts the sweeps in a burst.
// Every output is registered.
//
// Optional build macro: LFM_TRIANGLE_EN
//   Adds the tri_mode input. When tri_mode is latched high, the 2nd, 4th, ...
//   sweeps of a burst run downward from ftw_start + (len-1)*ftw_step.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         begin a burst (honoured in IDLE only)
//   abort         stop the burst at the next edge (wins over start)
//   ftw_start     FTW of the first sample of each (upward) sweep
//   ftw_step      per-sample FTW increment
//   sweep_len     samples per sweep (0 behaves as 1)
//   gap_len       idle cycles between sweeps (0 = back-to-back)
//   n_pulses      sweeps per burst (0 = continuous until abort)
//   tri_mode      triangle mode select (LFM_TRIANGLE_EN builds only)
//   ftw_out       FTW to the DDS, 0 when not valid
//   ftw_valid     ftw_out carries a sweep sample
//   sweep_sync    first sample of every sweep
//   busy          burst in progress
//   done          one-cycle pulse at the end of a finite burst
module lfm_sweep_ctrl #(
  parameter int unsigned N_PHASE = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_PHASE-1:0] ftw_start,
  input  logic [N_PHASE-1:0] ftw_step,
  input  logic [LEN_W-1:0]   sweep_len,
  input  logic [LEN_W-1:0]   gap_len,
  input  logic [CNT_W-1:0]   n_pulses,
`ifdef LFM_TRIANGLE_EN
  input  logic               tri_mode,
`endif
  output logic [N_PHASE-1:0] ftw_out,
  output logic               ftw_valid,
  output logic               sweep_sync,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    GAP
  } state_t;

  state_t state;

  // Shadow copies of the configuration, frozen for the whole burst.
  logic [N_PHASE-1:0] ftw_start_q;
  logic [N_PHASE-1:0] ftw_step_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   gap_q;
  logic               cont_q;

  logic [LEN_W-1:0]   sample_cnt;
  logic [LEN_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   pulse_cnt;

  logic [LEN_W-1:0]   eff_len;
  logic               pulses_remain;
  logic [N_PHASE-1:0] first_ftw;
  logic [N_PHASE-1:0] next_ftw;

`ifdef LFM_TRIANGLE_EN
  logic               tri_q;
  logic               down_q;
  logic               next_down;
  logic [N_PHASE-1:0] ftw_end_q;
  logic [N_PHASE-1:0] len_m1_ext;
  logic [N_PHASE-1:0] ftw_end_calc;
`endif

  always_comb begin
    eff_len       = (sweep_len == '0) ? LEN_W'(1) : sweep_len;
    // Evaluated at the last sample of a sweep, before pulse_cnt is decremented.
    pulses_remain = cont_q || (pulse_cnt != CNT_W'(1));
`ifdef LFM_TRIANGLE_EN
    // The multiply only sees the live config inputs while in IDLE. The sample
    // path itself uses just the add/subtract below.
    len_m1_ext   = N_PHASE'(eff_len - LEN_W'(1));
    ftw_end_calc = ftw_start + len_m1_ext * ftw_step;
    next_down    = tri_q && !down_q;
    first_ftw    = next_down ? ftw_end_q : ftw_start_q;
    next_ftw     = down_q ? (ftw_out - ftw_step_q) : (ftw_out + ftw_step_q);
`else
    first_ftw    = ftw_start_q;
    next_ftw     = ftw_out + ftw_step_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ftw_out     <= '0;
      ftw_valid   <= 1'b0;
      sweep_sync  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ftw_start_q <= '0;
      ftw_step_q  <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      cont_q      <= 1'b0;
      sample_cnt  <= '0;
      gap_cnt     <= '0;
      pulse_cnt   <= '0;
`ifdef LFM_TRIANGLE_EN
      tri_q       <= 1'b0;
      down_q      <= 1'b0;
      ftw_end_q   <= '0;
`endif
    end else if (abort) begin
      state      <= IDLE;
      ftw_out    <= '0;
      ftw_valid  <= 1'b0;
      sweep_sync <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      sweep_sync <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ftw_start_q <= ftw_start;
            ftw_step_q  <= ftw_step;
            len_q       <= eff_len;
            gap_q       <= gap_len;
            cont_q      <= (n_pulses == '0);
            pulse_cnt   <= n_pulses;
            sample_cnt  <= LEN_W'(1);
            ftw_out     <= ftw_start;
            ftw_valid   <= 1'b1;
            sweep_sync  <= 1'b1;
            busy        <= 1'b1;
            state       <= SWEEP;
`ifdef LFM_TRIANGLE_EN
            tri_q       <= tri_mode;
            down_q      <= 1'b0;
            ftw_end_q   <= ftw_end_calc;
`endif
          end
        end

        SWEEP: begin
          if (sample_cnt < len_q) begin
            ftw_out    <= next_ftw;
            sample_cnt <= sample_cnt + LEN_W'(1);
          end else begin
            if (!cont_q) pulse_cnt <= pulse_cnt - CNT_W'(1);
            if (!pulses_remain) begin
              state     <= IDLE;
              ftw_out   <= '0;
              ftw_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (gap_q != '0) begin
              state     <= GAP;
              ftw_out   <= '0;
              ftw_valid <= 1'b0;
              gap_cnt   <= LEN_W'(1);
            end else begin
              // Back-to-back: the next sweep starts with no bubble.
              ftw_out    <= first_ftw;
              ftw_valid  <= 1'b1;
              sweep_sync <= 1'b1;
              sample_cnt <= LEN_W'(1);
`ifdef LFM_TRIANGLE_EN
              down_q     <= next_down;
`endif
            end
          end
        end

        GAP: begin
          if (gap_cnt < gap_q) begin
            gap_cnt <= gap_cnt + LEN_W'(1);
          end else begin
            state      <= SWEEP;
            ftw_out    <= first_ftw;
            ftw_valid  <= 1'b1;
            sweep_sync <= 1'b1;
            sample_cnt <= LEN_W'(1);
`ifdef LFM_TRIANGLE_EN
            down_q     <= next_down;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          ftw_out   <= '0;
          ftw_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfm_sweep_ctrl.sv
// Scoreboard bench for lfm_sweep_ctrl. Expected output cycles are queued as
// stimulus is driven. A monitor pops and compares one entry per clock.
module tb_lfm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] ftw_start = '0;
  logic [31:0] ftw_step = '0;
  logic [15:0] sweep_len = '0;
  logic [15:0] gap_len = '0;
  logic [7:0]  n_pulses = '0;
  logic        tri_mode = 1'b0;
  logic [31:0] ftw_out;
  logic        ftw_valid, sweep_sync, busy, done;

  int checks = 0;
  int errors = 0;
  int tag = 0;

  typedef struct packed {
    logic        valid;
    logic        sync;
    logic        busy;
    logic        done;
    logic [31:0] ftw;
  } obs_t;

  obs_t sb[$];
  int   sb_tag[$];

  lfm_sweep_ctrl #(.N_PHASE(32), .LEN_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .ftw_start  (ftw_start),
    .ftw_step   (ftw_step),
    .sweep_len  (sweep_len),
    .gap_len    (gap_len),
    .n_pulses   (n_pulses),
`ifdef LFM_TRIANGLE_EN
    .tri_mode   (tri_mode),
`endif
    .ftw_out    (ftw_out),
    .ftw_valid  (ftw_valid),
    .sweep_sync (sweep_sync),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per rising edge, sampled 2 time units later.
  always @(posedge clk) begin
    obs_t exp_o, act_o;
    int   t;
    #2;
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      t     = sb_tag.pop_front();
      act_o = '{valid: ftw_valid, sync: sweep_sync, busy: busy, done: done, ftw: ftw_out};
      checks++;
      assert (act_o === exp_o) else begin
        errors++;
        $error("FAIL T%0d cycle: got v=%b s=%b b=%b d=%b ftw=%h, expected v=%b s=%b b=%b d=%b ftw=%h",
               t, act_o.valid, act_o.sync, act_o.busy, act_o.done, act_o.ftw,
               exp_o.valid, exp_o.sync, exp_o.busy, exp_o.done, exp_o.ftw);
      end
    end
  end

  task automatic push(input logic v, input logic s, input logic b, input logic d, input logic [31:0] f);
    sb.push_back('{valid: v, sync: s, busy: b, done: d, ftw: f});
    sb_tag.push_back(tag);
  endtask

  task automatic push_sweep(input logic [31:0] fs, input logic [31:0] st, input int unsigned len);
    int unsigned eff;
    logic [31:0] f;
    eff = (len == 0) ? 1 : len;
    f = fs;
    for (int unsigned i = 0; i < eff; i++) begin
      push(1'b1, (i == 0), 1'b1, 1'b0, f);
      f = f + st;
    end
  endtask

  task automatic push_gap(input int unsigned g);
    for (int unsigned i = 0; i < g; i++) push(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic push_idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) push(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic config_in(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] len,
                           input logic [15:0] gap, input logic [7:0] n);
    ftw_start = fs;
    ftw_step  = st;
    sweep_len = len;
    gap_len   = gap;
    n_pulses  = n;
  endtask

  // The start pulse is raised at a falling edge and seen on the next rising edge.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(posedge clk);
      #3;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL T%0d drain: %0d entries left, expected 0", tag, sb.size());
      sb.delete();
      sb_tag.delete();
    end
  endtask

  task automatic t1_expect();
    push_sweep(32'h0000A7C6, 32'd1, 4);
    push_gap(2);
    push_sweep(32'h0000A7C6, 32'd1, 4);
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push_idle(2);
  endtask

  initial begin
    // Reset state
    tag = 0;
    #1;
    checks++;
    assert ({ftw_out, ftw_valid, sweep_sync, busy, done} === 36'h0) else begin
      errors++;
      $error("FAIL T0 reset: got %h, expected 0", {ftw_out, ftw_valid, sweep_sync, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2);
    drain();

    // T1: basic burst with gap
    tag = 1;
    config_in(32'h0000A7C6, 32'd1, 16'd4, 16'd2, 8'd2);
    kick();
    t1_expect();
    drop_start();
    drain();

    // T2: back-to-back sweeps
    tag = 2;
    config_in(32'h00001000, 32'h00000010, 16'd3, 16'd0, 8'd3);
    kick();
    push_sweep(32'h00001000, 32'h10, 3);
    push_sweep(32'h00001000, 32'h10, 3);
    push_sweep(32'h00001000, 32'h10, 3);
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push_idle(1);
    drop_start();
    drain();

    // T3: modulo wrap
    tag = 3;
    config_in(32'hFFFFFFFE, 32'd1, 16'd4, 16'd0, 8'd1);
    kick();
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000001);
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drop_start();
    drain();

    // T4: continuous burst, abort on the 12th valid sample
    tag = 4;
    config_in(32'h00000100, 32'd3, 16'd5, 16'd0, 8'd0);
    kick();
    push_sweep(32'h100, 32'd3, 5);
    push_sweep(32'h100, 32'd3, 5);
    push_sweep(32'h100, 32'd3, 2);
    push_idle(4);
    drop_start();
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    // T5: start pulse and config changes mid-burst must not disturb it
    tag = 5;
    config_in(32'h0000A7C6, 32'd1, 16'd4, 16'd2, 8'd2);
    kick();
    t1_expect();
    drop_start();
    @(negedge clk);
    config_in(32'h00001234, 32'd5, 16'd9, 16'd0, 8'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Zero sweep length acts as one sample, with a single-cycle gap
    tag = 7;
    config_in(32'h00000042, 32'd7, 16'd0, 16'd1, 8'd2);
    kick();
    push_sweep(32'h42, 32'd7, 0);
    push_gap(1);
    push_sweep(32'h42, 32'd7, 0);
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push_idle(1);
    drop_start();
    drain();

    // Abort wins over a simultaneous start
    tag = 8;
    config_in(32'h00000500, 32'd1, 16'd3, 16'd0, 8'd1);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    push_idle(3);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    drain();

    // T5b: asynchronous reset mid-sweep
    tag = 9;
    config_in(32'h00000010, 32'd2, 16'd8, 16'd0, 8'd1);
    kick();
    push_sweep(32'h10, 32'd2, 3);
    drop_start();
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({ftw_out, ftw_valid, sweep_sync, busy, done} === 36'h0) else begin
      errors++;
      $error("FAIL T9 async_reset: got %h, expected 0", {ftw_out, ftw_valid, sweep_sync, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    drain();

`ifdef LFM_TRIANGLE_EN
    // T6: triangle mode
    tag = 6;
    config_in(32'd100, 32'd10, 16'd3, 16'd0, 8'd2);
    tri_mode = 1'b1;
    kick();
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'd100);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'd110);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'd120);
    push(1'b1, 1'b1, 1'b1, 1'b0, 32'd120);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'd110);
    push(1'b1, 1'b0, 1'b1, 1'b0, 32'd100);
    push(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drop_start();
    drain();
    tri_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
